line_rasterizer: RTL
====================

Name: line_rasterizer

Overview:
Upstream stage of AHBMemoryManager: converts a line-segment command (two endpoints) into a paced stream of single-pixel draw requests using integer Bresenham.
Each pixel is presented as x/y plus a one-cycle enable pulse, matching the memory manager's draw-pixel input.
Pulses are spaced by a fixed period, so every AHB write completes before the next request.
Color and flip_buffer are driven to the memory manager by other logic, not by this block.

Parameters:
COORD_W, 10, width of input endpoint coordinates (unsigned)
PIXEL_PERIOD, 4, cycles from one enable pulse to the next (minimum 2; 4 covers enable + address phase + data phase + idle)

Ports:
clk  in  1  system clock, rising-edge
n_rst  in  1  asynchronous active-low reset
start  in  1  one-cycle request to draw a line; sampled only in IDLE
x0  in  COORD_W  start point x
y0  in  COORD_W  start point y
x1  in  COORD_W  end point x
y1  in  COORD_W  end point y
x  out  32  current pixel x, zero-extended; drives memory manager x
y  out  32  current pixel y, zero-extended; drives memory manager y
enable  out  1  one-cycle pulse per pixel; drives memory manager enable
busy  out  1  high while a line is in progress
done  out  1  one-cycle pulse after the last pixel's period ends

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low (clk, n_rst).
- Reset: state=IDLE; x=0, y=0, enable=0, busy=0, done=0; all internal registers cleared.
- Reset asserted mid-line aborts immediately. No further pulses; done is not issued.
- States: IDLE, SETUP, PLOT, WAIT, DONE.
- IDLE:
  - start=1 latches x0,y0,x1,y1 and goes to SETUP.
  - busy rises the following cycle.
  - start in any other state is ignored; no queueing.
- SETUP (1 cycle):
  - dx=|x1-x0|, dy=-|y1-y0|.
  - sx=+1 if x0<x1 else -1; sy=+1 if y0<y1 else -1.
  - err=dx+dy; current point=(x0,y0).
  - Go to PLOT.
- Widths: dx, dy, err signed COORD_W+2 bits; e2=2*err signed COORD_W+3 bits. No overflow for any COORD_W input.
- PLOT (1 cycle):
  - enable=1; x/y show the current point (registered, valid in the same cycle as enable).
  - If current point == (x1,y1), set the last flag.
  - Otherwise compute the next point into internal registers:
    - e2=2*err.
    - If e2>=dy: err+=dy, cx+=sx.
    - If e2<=dx: err+=dx, cy+=sy.
    - Both updates may occur in the same step.
  - Go to WAIT.
- WAIT:
  - Lasts PIXEL_PERIOD-1 cycles, counted by an internal counter.
  - x/y outputs hold the plotted pixel for the whole period.
  - On expiry: go to DONE if the last flag is set, else load the next point onto x/y and go to PLOT.
- DONE (1 cycle): done=1, busy=1; then IDLE with busy=0.
- Latency:
  - First enable occurs 2 cycles after the start-sampling edge.
  - Consecutive enables are exactly PIXEL_PERIOD cycles apart.
  - done occurs PIXEL_PERIOD cycles after the last enable.
- Pixel count = max(dx,|dy|)+1. Every pixel from (x0,y0) to (x1,y1) is emitted, both endpoints included, with no duplicates.
- Degenerate line (x0==x1, y0==y1): exactly one pulse, then done.
- All octants are supported, including lines drawn right-to-left and bottom-to-top.
- Coordinates never wrap: intermediate points stay within the bounding box of the endpoints.
- Outputs x/y bits [31:COORD_W] are always 0.
- x/y keep their last value after done until the next line's first PLOT.

Test Plan:
- Reset: hold n_rst=0 mid-line (after 2nd enable) -> x=y=0, enable=busy=done=0 asynchronously; no pulses after release.
- Horizontal: start (0,0)->(3,0), PIXEL_PERIOD=4 -> enables at start+2,+6,+10,+14 with x=0,1,2,3 and y=0; done at start+18; busy low at start+19.
- Diagonal: (0,0)->(2,2) -> exactly 3 pulses at (0,0),(1,1),(2,2), then done.
- Reverse shallow: (3,1)->(0,0) -> pulses at (3,1),(2,1),(1,0),(0,0), in order.
- Degenerate plus ignored start: (5,5)->(5,5) with start re-pulsed during WAIT -> one pulse at (5,5), one done, second start ignored.
- Chained with AHBMemoryManager: steep line (0x55,0x11)->(0x56,0x14) -> 4 AHB writes to the pixel addresses in order, none overlapping.

Source files
------------

// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer: turns a two-endpoint segment into a paced stream of
// single-pixel draw requests (x/y plus a one-cycle enable) for the memory manager.
module line_rasterizer #(
  parameter int COORD_W      = 10,
  parameter int PIXEL_PERIOD = 4
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  output logic [31:0]        x,
  output logic [31:0]        y,
  output logic               enable,
  output logic               busy,
  output logic               done
);

  localparam int DW    = COORD_W + 2;
  localparam int EW    = COORD_W + 3;
  localparam int CNT_W = (PIXEL_PERIOD > 2) ? $clog2(PIXEL_PERIOD) : 1;
  localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(PIXEL_PERIOD - 2);

  typedef enum logic [2:0] {IDLE, SETUP, PLOT, WAIT, DONE} state_t;

  state_t state_reg, state_next;

  logic [COORD_W-1:0] x0_reg, y0_reg, x1_reg, y1_reg;
  logic [COORD_W-1:0] cx_reg, cy_reg, px_reg, py_reg;
  logic signed [DW-1:0] dx_reg, dy_reg, err_reg;
  logic sx_reg, sy_reg, last_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic signed [DW-1:0] diff_x, diff_y, abs_x, abs_y, err_step;
  logic signed [EW-1:0] e2, dx_ext, dy_ext;
  logic step_x, step_y, wait_over, at_end;

  // Setup deltas, evaluated from the latched endpoints.
  always_comb begin
    diff_x = $signed({2'b00, x1_reg}) - $signed({2'b00, x0_reg});
    diff_y = $signed({2'b00, y1_reg}) - $signed({2'b00, y0_reg});
    abs_x  = diff_x[DW-1] ? -diff_x : diff_x;
    abs_y  = diff_y[DW-1] ? -diff_y : diff_y;
  end

  always_comb begin
    e2       = $signed({err_reg, 1'b0});
    dx_ext   = $signed({dx_reg[DW-1], dx_reg});
    dy_ext   = $signed({dy_reg[DW-1], dy_reg});
    step_x   = (e2 >= dy_ext);
    step_y   = (e2 <= dx_ext);
    err_step = err_reg + (step_x ? dy_reg : '0) + (step_y ? dx_reg : '0);
    at_end   = (cx_reg == x1_reg) && (cy_reg == y1_reg);
  end

  assign wait_over = (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SETUP;
      SETUP:   state_next = PLOT;
      PLOT:    state_next = WAIT;
      WAIT:    if (wait_over) state_next = last_reg ? DONE : PLOT;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      x0_reg   <= '0;
      y0_reg   <= '0;
      x1_reg   <= '0;
      y1_reg   <= '0;
      cx_reg   <= '0;
      cy_reg   <= '0;
      px_reg   <= '0;
      py_reg   <= '0;
      dx_reg   <= '0;
      dy_reg   <= '0;
      err_reg  <= '0;
      sx_reg   <= 1'b0;
      sy_reg   <= 1'b0;
      last_reg <= 1'b0;
      cnt_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          x0_reg <= x0;
          y0_reg <= y0;
          x1_reg <= x1;
          y1_reg <= y1;
        end
        SETUP: begin
          dx_reg   <= abs_x;
          dy_reg   <= -abs_y;
          err_reg  <= abs_x - abs_y;
          sx_reg   <= (x0_reg < x1_reg);
          sy_reg   <= (y0_reg < y1_reg);
          cx_reg   <= x0_reg;
          cy_reg   <= y0_reg;
          px_reg   <= x0_reg;
          py_reg   <= y0_reg;
          last_reg <= 1'b0;
        end
        PLOT: begin
          cnt_reg <= '0;
          // Next point is precomputed here; outputs keep showing the plotted pixel.
          if (at_end) begin
            last_reg <= 1'b1;
          end else begin
            err_reg <= err_step;
            if (step_x) cx_reg <= sx_reg ? cx_reg + ONE : cx_reg - ONE;
            if (step_y) cy_reg <= sy_reg ? cy_reg + ONE : cy_reg - ONE;
          end
        end
        WAIT: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (wait_over && !last_reg) begin
            px_reg <= cx_reg;
            py_reg <= cy_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign x      = {{(32-COORD_W){1'b0}}, px_reg};
  assign y      = {{(32-COORD_W){1'b0}}, py_reg};
  assign enable = (state_reg == PLOT);
  assign busy   = (state_reg != IDLE);
  assign done   = (state_reg == DONE);

endmodule
